// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the NxN matrix multiplier.
package matrix_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    // Result width wide enough that a sum of N full-scale products cannot overflow.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int idx_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// Registered multiply-accumulate; sum is the value the accumulator takes at the next edge.
module matrix_mac_unit
    import matrix_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr_acc,
    input  logic          signed_mode,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] sum
);

    logic signed [AW-1:0] a_x;
    logic signed [AW-1:0] b_x;
    logic        [AW-1:0] acc_q;
    logic        [AW-1:0] acc_d;

    // One extra MSB selects sign- or zero-extension from a single signed multiply.
    always_comb begin
        a_x   = AW'($signed({signed_mode & a[DW-1], a}));
        b_x   = AW'($signed({signed_mode & b[DW-1], b}));
        sum   = (clr_acc ? '0 : acc_q) + AW'(a_x * b_x);
        acc_d = en ? sum : acc_q;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

endmodule

// File: rtl/matrix_mult_nxn.sv
// NxN integer matrix multiplier: streams A then B in, one MAC per cycle, streams C out.
module matrix_mult_nxn
    import matrix_pkg::*;
#(
    parameter  int N  = 2,
    parameter  int DW = 16,
    localparam int AW = acc_width(N, DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int NN = N * N;
    localparam int IW = idx_width(N);
    localparam int EW = idx_width(NN);
    localparam int BW = idx_width(2 * NN);

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [EW-1:0] r_q, r_d;
    logic          signed_q, signed_d;
    logic [DW-1:0] a_buf_q [NN];
    logic [DW-1:0] a_buf_d [NN];
    logic [DW-1:0] b_buf_q [NN];
    logic [DW-1:0] b_buf_d [NN];
    logic [AW-1:0] c_buf_q [NN];
    logic [AW-1:0] c_buf_d [NN];

    logic          in_fire;
    logic          out_fire;
    logic          last_mac;
    logic [EW-1:0] a_idx;
    logic [EW-1:0] b_idx;
    logic [EW-1:0] c_idx;
    logic [AW-1:0] mac_sum;

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (int'(r_q) == NN - 1);
    assign out_data  = out_valid ? c_buf_q[r_q] : '0;
    assign busy      = (state_q != IDLE);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_mac = (int'(i_q) == N - 1) && (int'(j_q) == N - 1) && (int'(k_q) == N - 1);
    assign a_idx    = EW'(int'(i_q) * N + int'(k_q));
    assign b_idx    = EW'(int'(k_q) * N + int'(j_q));
    assign c_idx    = EW'(int'(i_q) * N + int'(j_q));

    matrix_mac_unit #(.DW(DW), .AW(AW)) u_mac (
        .clk         (clk),
        .rst         (rst),
        .en          (state_q == COMPUTE),
        .clr_acc     (k_q == '0),
        .signed_mode (signed_q),
        .a           (a_buf_q[a_idx]),
        .b           (b_buf_q[b_idx]),
        .sum         (mac_sum)
    );

    // NOTE: every _d starts as a copy of its _q, so no branch can leave one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        r_d      = r_q;
        signed_d = signed_q;
        a_buf_d  = a_buf_q;
        b_buf_d  = b_buf_q;
        c_buf_d  = c_buf_q;

        case (state_q)
            IDLE, LOAD: begin
                if (in_fire) begin
                    if (state_q == IDLE) signed_d = in_signed;
                    if (int'(beat_q) < NN) a_buf_d[EW'(beat_q)] = in_data;
                    else                   b_buf_d[EW'(int'(beat_q) - NN)] = in_data;
                    if (int'(beat_q) == 2 * NN - 1) begin
                        beat_d  = '0;
                        state_d = COMPUTE;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                        state_d = LOAD;
                    end
                end
            end

            COMPUTE: begin
                // Loop order i, j, k; the final k-step commits the running sum to C[i][j].
                if (int'(k_q) == N - 1) begin
                    c_buf_d[c_idx] = mac_sum;
                    k_d            = '0;
                    if (int'(j_q) == N - 1) begin
                        j_d = '0;
                        i_d = (int'(i_q) == N - 1) ? '0 : i_q + IW'(1);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    k_d = k_q + IW'(1);
                end
                if (last_mac) state_d = DRAIN;
            end

            DRAIN: begin
                if (out_fire) begin
                    if (int'(r_q) == NN - 1) begin
                        r_d     = '0;
                        state_d = IDLE;
                    end else begin
                        r_d = r_q + EW'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            r_q      <= '0;
            signed_q <= 1'b0;
            // NOTE: the operand/result buffers are cleared on reset because reset defines them as zero.
            for (int e = 0; e < NN; e++) begin
                a_buf_q[e] <= '0;
                b_buf_q[e] <= '0;
                c_buf_q[e] <= '0;
            end
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            r_q      <= r_d;
            signed_q <= signed_d;
            a_buf_q  <= a_buf_d;
            b_buf_q  <= b_buf_d;
            c_buf_q  <= c_buf_d;
        end
    end

endmodule

// File: tb/tb_matrix_mult_nxn.sv
// Scoreboard bench: N=2 directed cases plus golden-model runs on N=3 and N=4 instances.
module tb_matrix_mult_nxn;

    localparam int DW = 16;

    typedef struct {
        logic [33:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid_v  [3];
    logic        in_ready_v  [3];
    logic [15:0] in_data_v   [3];
    logic        in_signed_v [3];
    logic        out_valid_v [3];
    logic        out_ready_v [3];
    logic [33:0] out_data_v  [3];
    logic        out_last_v  [3];
    logic        busy_v      [3];

    int   tests;
    int   fails;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int GN  = g + 2;
        localparam int GAW = 2 * DW + $clog2(GN);
        logic [GAW-1:0] od;

        matrix_mult_nxn #(.N(GN), .DW(DW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data_v[g]),
            .in_signed (in_signed_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .out_data  (od),
            .out_last  (out_last_v[g]),
            .busy      (busy_v[g])
        );

        assign out_data_v[g] = 34'(od);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void golden(input int n, input bit sgn, input logic [15:0] a [16],
                                   input logic [15:0] b [16], output logic [33:0] c [16]);
        longint mask = (longint'(1) << (2 * DW + $clog2(n))) - 1;
        for (int e = 0; e < 16; e++) c[e] = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                longint s = 0;
                for (int k = 0; k < n; k++) begin
                    longint x = sgn ? longint'($signed(a[i*n+k])) : longint'(a[i*n+k]);
                    longint y = sgn ? longint'($signed(b[k*n+j])) : longint'(b[k*n+j]);
                    s += x * y;
                end
                c[i*n+j] = 34'(s & mask);
            end
        end
    endfunction

    task automatic check_idle(input int d, input string tag);
        check({tag, "_in_ready"},  64'(in_ready_v[d]),  64'd1);
        check({tag, "_busy"},      64'(busy_v[d]),      64'd0);
        check({tag, "_out_valid"}, 64'(out_valid_v[d]), 64'd0);
        check({tag, "_out_last"},  64'(out_last_v[d]),  64'd0);
        check({tag, "_out_data"},  64'(out_data_v[d]),  64'd0);
    endtask

    // Drives the 2n^2 operand beats; in_signed is inverted after the first beat to prove it is latched.
    task automatic load_operands(input int d, input int n, input bit sgn,
                                 input logic [15:0] a [16], input logic [15:0] b [16]);
        int nn = n * n;
        for (int beat = 0; beat < 2 * nn; beat++) begin
            @(negedge clk);
            in_valid_v[d]  = 1'b1;
            in_data_v[d]   = (beat < nn) ? a[beat] : b[beat-nn];
            in_signed_v[d] = (beat == 0) ? sgn : ~sgn;
            check("load_in_ready", 64'(in_ready_v[d]), 64'd1);
            @(posedge clk);
        end
    endtask

    task automatic run_op(input string name, input int d, input int n, input bit sgn,
                          input logic [15:0] a [16], input logic [15:0] b [16],
                          input logic [33:0] exp_c [16], input bit bp, input bit junk);
        int          nn = n * n;
        int          m;
        int          got;
        int          cyc;
        bit          stalled;
        logic [33:0] held_data;
        logic        held_last;
        exp_t        e;

        for (int r = 0; r < nn; r++) sb.push_back('{exp_c[r], r == nn - 1});
        load_operands(d, n, sgn, a, b);

        @(negedge clk);
        in_valid_v[d] = junk;
        in_data_v[d]  = 16'hDEAD;
        check({name, "_busy"},         64'(busy_v[d]),     64'd1);
        check({name, "_compute_ready"}, 64'(in_ready_v[d]), 64'd0);
        m = 0;
        while (!out_valid_v[d] && m < 200) begin
            @(negedge clk);
            m++;
        end
        check({name, "_latency"}, 64'(m), 64'(n * n * n));

        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        while (got < nn && cyc < 200) begin
            out_ready_v[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
            check({name, "_drain_in_ready"}, 64'(in_ready_v[d]), 64'd0);
            check({name, "_out_valid"},      64'(out_valid_v[d]), 64'd1);
            if (stalled) begin
                check({name, "_hold_data"}, 64'(out_data_v[d]), 64'(held_data));
                check({name, "_hold_last"}, 64'(out_last_v[d]), 64'(held_last));
            end
            if (out_valid_v[d] && out_ready_v[d]) begin
                if (sb.size() == 0) begin
                    check({name, "_sb_empty"}, 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({name, "_data"}, 64'(out_data_v[d]), 64'(e.data));
                    check({name, "_last"}, 64'(out_last_v[d]), 64'(e.last));
                end
                got++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_data = out_data_v[d];
                held_last = out_last_v[d];
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b0;
        check({name, "_beats"}, 64'(got), 64'(nn));
        if (!bp) check({name, "_back_to_back"}, 64'(cyc), 64'(nn));
        check_idle(d, {name, "_done"});
    endtask

    initial begin
        logic [15:0] ma [16];
        logic [15:0] mb [16];
        logic [15:0] mz [16];
        logic [15:0] mf [16];
        logic [15:0] ms [16];
        logic [33:0] ec [16];

        tests = 0;
        fails = 0;
        rst   = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid_v[d]  = 1'b0;
            in_data_v[d]   = '0;
            in_signed_v[d] = 1'b0;
            out_ready_v[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) check_idle(d, "reset");

        ma = '{0: 16'd1, 1: 16'd2, 2: 16'd3, 3: 16'd4, default: 16'd0};
        mb = '{0: 16'd5, 1: 16'd6, 2: 16'd7, 3: 16'd8, default: 16'd0};
        mz = '{0: 16'd5, 1: 16'd6, 2: 16'd7, 3: 16'd0, default: 16'd0};
        ms = '{0: 16'hFFFF, 1: 16'd2, 2: 16'd3, 3: 16'hFFFC, default: 16'd0};
        mf = '{0: 16'hFFFF, 1: 16'hFFFF, 2: 16'hFFFF, 3: 16'hFFFF, default: 16'd0};

        ec = '{0: 34'h13, 1: 34'h16, 2: 34'h2B, 3: 34'h32, default: 34'h0};
        run_op("unsigned", 0, 2, 1'b0, ma, mb, ec, 1'b0, 1'b1);

        ec = '{0: 34'h13, 1: 34'h06, 2: 34'h2B, 3: 34'h12, default: 34'h0};
        run_op("zero_elem", 0, 2, 1'b0, ma, mz, ec, 1'b0, 1'b0);

        ec = '{0: 34'h9, 1: 34'hA, 2: 34'h1_FFFF_FFF3, 3: 34'h1_FFFF_FFF2, default: 34'h0};
        run_op("signed", 0, 2, 1'b1, ms, mb, ec, 1'b0, 1'b1);

        ec = '{0: 34'h1_FFFC_0002, 1: 34'h1_FFFC_0002, 2: 34'h1_FFFC_0002, 3: 34'h1_FFFC_0002,
               default: 34'h0};
        run_op("full_scale", 0, 2, 1'b0, mf, mf, ec, 1'b0, 1'b0);

        ec = '{0: 34'h13, 1: 34'h16, 2: 34'h2B, 3: 34'h32, default: 34'h0};
        run_op("backpressure", 0, 2, 1'b0, ma, mb, ec, 1'b1, 1'b1);

        load_operands(0, 2, 1'b0, ma, mb);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(0, "mid_reset");
        run_op("after_reset", 0, 2, 1'b0, ma, mb, ec, 1'b0, 1'b0);

        for (int d = 1; d < 3; d++) begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int e = 0; e < 16; e++) begin
                    ma[e] = 16'($urandom);
                    mb[e] = 16'($urandom);
                end
                if (pass == 1) begin
                    ma[0] = 16'h8000;
                    mb[0] = 16'h8000;
                end
                golden(d + 2, pass == 1, ma, mb, ec);
                run_op(pass == 1 ? "golden_signed" : "golden_unsigned", d, d + 2, pass == 1,
                       ma, mb, ec, pass == 1, pass == 0);
            end
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
